// File: rtl/pwl_delay_pkg.sv
// Shared types for the cycle-aligned PWL delay line.
// A producer signals a new segment by bumping the seq field of its pwl record.
package pwl_delay_pkg;

  localparam int unsigned SeqW   = 4;
  localparam int unsigned StampW = 32;

  typedef struct {
    real             a;
    real             b;
    real             t0;
    logic [SeqW-1:0] seq;
  } pwl;

  typedef struct {
    real               a;
    real               b;
    real               t0;
    logic [StampW-1:0] stamp;
  } entry_t;

  // Age of a stamp relative to the cycle counter, modulo 2^cw.
  function automatic logic [StampW-1:0] age(input logic [StampW-1:0] cnt,
                                            input logic [StampW-1:0] stamp,
                                            input int unsigned       cw);
    logic [StampW-1:0] mask;
    mask = (cw >= StampW) ? '1 : ((StampW'(1) << cw) - StampW'(1));
    return (cnt - stamp) & mask;
  endfunction

endpackage

// File: rtl/pwl_delay_chan.sv
// One delay-line channel: event staging, stamped FIFO, pop/push/bypass and
// sticky overflow/coalesce flags.
module pwl_delay_chan
  import pwl_delay_pkg::*;
#(
  parameter int unsigned Depth  = 8,
  parameter int unsigned DelayW = 6,
  parameter int unsigned CycW   = 16,
  parameter real         Tclk   = 1e-9,
  parameter real         Scale  = 1.0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DelayW-1:0] delay_i,
  input  logic [CycW-1:0]   cnt_i,
  input  pwl                in_i,
  output pwl                out_o,
  output logic              overflow_o,
  output logic              coalesced_o,
  output logic              nonempty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);

  entry_t          mem [Depth];
  entry_t          head;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [OccW-1:0] count_q, count_after_pop;
  logic [SeqW-1:0] seq_q, n_ev;
  logic            staged, empty, pop, bypass, push, drop;
  real             shift;

  always_comb begin
    n_ev            = in_i.seq - seq_q;
    staged          = (n_ev != '0);
    empty           = (count_q == '0);
    head            = mem[rd_ptr_q];
    pop             = !empty &&
                      (age(StampW'(cnt_i), head.stamp, CycW) >= StampW'(delay_i));
    count_after_pop = count_q - OccW'(pop);
    // Zero delay with nothing queued: the staged segment skips the FIFO entirely.
    bypass          = staged && (delay_i == '0) && empty;
    push            = staged && !bypass && (count_after_pop != OccW'(Depth));
    drop            = staged && !bypass && (count_after_pop == OccW'(Depth));
    shift           = real'(delay_i) * Tclk;
  end

  assign nonempty_o = !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      // Swallow every event seen while reset is held.
      seq_q       <= in_i.seq;
      overflow_o  <= 1'b0;
      coalesced_o <= 1'b0;
      out_o.a     <= 0.0;
      out_o.b     <= 0.0;
      out_o.t0    <= $realtime;
      out_o.seq   <= '0;
    end else begin
      seq_q <= in_i.seq;
      if (n_ev > SeqW'(1)) coalesced_o <= 1'b1;
      if (drop) overflow_o <= 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        out_o.a   <= Scale * head.a;
        out_o.b   <= Scale * head.b;
        out_o.t0  <= head.t0 + shift;
        out_o.seq <= out_o.seq + SeqW'(1);
      end else if (bypass) begin
        out_o.a   <= Scale * in_i.a;
        out_o.b   <= Scale * in_i.b;
        out_o.t0  <= in_i.t0;
        out_o.seq <= out_o.seq + SeqW'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      count_q <= count_after_pop + OccW'(push);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr_q].a     <= in_i.a;
      mem[wr_ptr_q].b     <= in_i.b;
      mem[wr_ptr_q].t0    <= in_i.t0;
      mem[wr_ptr_q].stamp <= StampW'(cnt_i);
    end
  end

endmodule

// File: rtl/pwl_delay_line.sv
// Multi-channel PWL transport delay: shared cycle counter and delay fan-out
// feeding NCH independent buffered channels.
module pwl_delay_line
  import pwl_delay_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 6,
  parameter int unsigned CW    = 16,
  parameter real         TCLK  = 1e-9,
  parameter real         SCALE = 1.0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  delay_cyc,
  input  pwl             in [NCH],
  output pwl             out [NCH],
  output logic [NCH-1:0] overflow,
  output logic [NCH-1:0] coalesced,
  output logic           busy
);

  logic [CW-1:0]  cnt_q;
  logic [NCH-1:0] nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + CW'(1);
  end

  assign busy = |nonempty;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    pwl_delay_chan #(
      .Depth (DEPTH),
      .DelayW(DW),
      .CycW  (CW),
      .Tclk  (TCLK),
      .Scale (SCALE)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .delay_i    (delay_cyc),
      .cnt_i      (cnt_q),
      .in_i       (in[k]),
      .out_o      (out[k]),
      .overflow_o (overflow[k]),
      .coalesced_o(coalesced[k]),
      .nonempty_o (nonempty[k])
    );
  end

endmodule

// File: tb/tb_pwl_delay_line.sv
// Self-checking bench for pwl_delay_line: vector table plus scoreboarded
// sequences for reset, overflow, coalescing, bypass and delay changes.
module tb_pwl_delay_line;
  import pwl_delay_pkg::*;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 6;
  localparam int unsigned CW    = 7;
  localparam real         TCLK  = 1e-9;
  localparam real         SCALE = 2.0;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  delay_cyc = '0;
  pwl             din  [NCH];
  pwl             dout [NCH];
  logic [NCH-1:0] overflow, coalesced;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int base   = 0;

  typedef struct {
    int  ch;
    real a;
    real b;
    real t0;
    int  rel;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    int  ch;
    int  dly;
    real a;
    real b;
    real t0;
    real ea;
    real eb;
    real et0;
  } vec_t;
  vec_t vecs [$];

  logic [SeqW-1:0] last_seq [NCH];

  pwl_delay_line #(
    .NCH  (NCH),
    .DEPTH(DEPTH),
    .DW   (DW),
    .CW   (CW),
    .TCLK (TCLK),
    .SCALE(SCALE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .delay_cyc(delay_cyc),
    .in       (din),
    .out      (dout),
    .overflow (overflow),
    .coalesced(coalesced),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    real tol, diff;
    tol  = 1e-9 * ((exp < 0.0) ? -exp : exp) + 1e-24;
    diff = (act > exp) ? act - exp : exp - act;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %g, expected %g (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input int ch, input real a, input real b, input real t0);
    din[ch].a   = a;
    din[ch].b   = b;
    din[ch].t0  = t0;
    din[ch].seq = din[ch].seq + SeqW'(1);
  endtask

  task automatic push_exp(input int ch, input real a, input real b, input real t0,
                          input int rel);
    exp_t e;
    e.ch = ch; e.a = a; e.b = b; e.t0 = t0; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic add_vec(input int ch, input int dly, input real a, input real b,
                         input real t0, input real ea, input real eb, input real et0);
    vec_t v;
    v.ch = ch; v.dly = dly; v.a = a; v.b = b; v.t0 = t0;
    v.ea = ea; v.eb = eb; v.et0 = et0;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = edge_n;
  endtask

  // Release monitor: every output event must match the head of the scoreboard.
  initial begin
    for (int k = 0; k < NCH; k++) last_seq[k] = '0;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (rst) begin
          last_seq[k] = dout[k].seq;
        end else if (dout[k].seq != last_seq[k]) begin
          last_seq[k] = dout[k].seq;
          if (sb.size() == 0 || sb[0].ch != k) begin
            checks++;
            errors++;
            $display("FAIL unexpected_release: ch%0d a=%g b=%g t0=%g at edge %0d, expected none",
                     k, dout[k].a, dout[k].b, dout[k].t0, edge_n);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk_real("release_a", dout[k].a, e.a);
            chk_real("release_b", dout[k].b, e.b);
            chk_real("release_t0", dout[k].t0, e.t0);
            chk_int("release_edge", edge_n, e.rel);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    real t_rst;
    int  other_seq;
    int  c;

    for (int k = 0; k < NCH; k++) begin
      din[k].a = 0.0; din[k].b = 0.0; din[k].t0 = 0.0; din[k].seq = '0;
    end

    add_vec(0, 4,  0.5,   1e6,  10.3e-9, 1.0,  2e6,  14.3e-9);
    add_vec(1, 1, -0.25,  3e5,  2e-9,   -0.5,  6e5,  3e-9);
    add_vec(0, 7,  1.5,  -2e6,  50e-9,   3.0, -4e6,  57e-9);
    add_vec(1, 0,  0.75,  0.0,  5e-9,    1.5,  0.0,  5e-9);
    add_vec(0, 63, 0.1,   1.0,  0.0,     0.2,  2.0,  63e-9);

    do_reset();

    // Reset mid-burst: three entries queued, then an async pulse.
    @(negedge clk); delay_cyc = DW'(20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); send(0, 1.0 + i, 2.0, 1e-9 * i);
    end
    @(negedge clk);
    chk_int("busy_queued", busy, 1);
    #2;
    rst   = 1'b1;
    t_rst = $realtime;
    #1 send(0, 9.0, 9.0, 9e-9);
    #1;
    for (int k = 0; k < NCH; k++) begin
      chk_real("reset_out_a", dout[k].a, 0.0);
      chk_real("reset_out_b", dout[k].b, 0.0);
      chk_real("reset_out_t0", dout[k].t0, t_rst);
    end
    chk_int("reset_overflow", overflow, 0);
    chk_int("reset_coalesced", coalesced, 0);
    chk_int("reset_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = edge_n;
    repeat (30) @(negedge clk);
    chk_int("no_flushed_release", dout[0].seq, 0);
    chk_int("busy_after_flush", busy, 0);

    // Table-driven single-event delays, including bypass and the max delay.
    foreach (vecs[i]) begin
      @(negedge clk); delay_cyc = DW'(vecs[i].dly);
      @(negedge clk);
      other_seq = int'(dout[1 - vecs[i].ch].seq);
      send(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].t0);
      push_exp(vecs[i].ch, vecs[i].ea, vecs[i].eb, vecs[i].et0, edge_n + 1 + vecs[i].dly);
      repeat (vecs[i].dly + 3) @(negedge clk);
      chk_int("other_channel_quiet", dout[1 - vecs[i].ch].seq, other_seq);
      chk_int("vector_drained", sb.size(), 0);
      chk_int("vector_busy_idle", busy, 0);
    end
    chk_int("single_events_not_coalesced", coalesced, 0);

    // Burst of 10 into an 8-deep FIFO at delay 20: last two dropped.
    do_reset();
    @(negedge clk); delay_cyc = DW'(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 8) chk_int("no_overflow_at_full", overflow[0], 0);
      send(0, 0.1 * (i + 1), 1000.0 * (i + 1), 1e-9 * (i + 1));
      if (i < 8)
        push_exp(0, SCALE * 0.1 * (i + 1), SCALE * 1000.0 * (i + 1),
                 1e-9 * (i + 1) + 20.0 * TCLK, edge_n + 1 + 20);
    end
    @(negedge clk);
    chk_int("burst_overflow0", overflow[0], 1);
    chk_int("burst_overflow1", overflow[1], 0);
    chk_int("burst_busy", busy, 1);
    repeat (25) @(negedge clk);
    chk_int("burst_drained", sb.size(), 0);
    chk_int("burst_idle", busy, 0);

    // Full FIFO with an eligible head: pop and push on the same edge.
    do_reset();
    @(negedge clk); delay_cyc = DW'(8);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk_int("full_pop_no_overflow", overflow[0], 0);
        chk_int("full_pop_busy", busy, 1);
      end
      send(0, -0.5 * i, 10.0 * i, 3e-9 * i);
      push_exp(0, SCALE * -0.5 * i, SCALE * 10.0 * i, 3e-9 * i + 8.0 * TCLK,
               edge_n + 1 + 8);
    end
    repeat (12) @(negedge clk);
    chk_int("full_pop_overflow_end", overflow[0], 0);
    chk_int("full_pop_drained", sb.size(), 0);

    // Two events in one period at zero delay: last wins, same-edge bypass.
    @(negedge clk); delay_cyc = '0;
    @(negedge clk);
    send(1, 1.0, 3.0, 20e-9);
    #1 send(1, 2.5, -7.0, 33e-9);
    push_exp(1, 5.0, -14.0, 33e-9, edge_n + 1);
    @(negedge clk);
    chk_int("coalesced1", coalesced[1], 1);
    chk_int("coalesced0", coalesced[0], 0);
    repeat (3) @(negedge clk);
    chk_int("coalesce_drained", sb.size(), 0);
    chk_int("coalesce_busy", busy, 0);

    // Delay drop from 10 to 2 with the stamps straddling the counter wrap.
    do_reset();
    @(negedge clk); delay_cyc = DW'(10);
    while (edge_n - base - 1 < 123) @(negedge clk);
    c = edge_n + 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      send(0, 0.25 * (i + 1), -100.0 * (i + 1), 7e-9 * i);
      push_exp(0, SCALE * 0.25 * (i + 1), SCALE * -100.0 * (i + 1), 7e-9 * i + 2.0 * TCLK,
               c + 6 + i);
    end
    @(negedge clk);
    @(negedge clk);
    chk_int("decrease_pending", sb.size(), 5);
    delay_cyc = DW'(2);
    repeat (8) @(negedge clk);
    chk_int("decrease_drained", sb.size(), 0);
    chk_int("decrease_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
